// File: rtl/ccu_snoop_responder.sv
// ---------------------------------------------------------------------------
// ccu_snoop_responder
//
// Purpose:
//   Snooped-side end of the ACE snoop channels for one cached master. Accepts
//   a snoop on AC, looks the line up in the cache, answers on CR, streams the
//   line on CD in wrap order starting at the snooped beat, then issues one
//   state-update command to the cache. Exactly one snoop is in flight.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   ac_valid_i/ac_ready_o     snoop request handshake; ac_addr_i, ac_snoop_i
//   cr_valid_o/cr_ready_i     snoop response handshake; cr_resp_o
//                             = {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   cd_valid_o/cd_ready_i     snoop data handshake; cd_data_o, cd_last_o
//   lk_req_o/lk_addr_o        cache lookup request (held until lk_valid_i)
//   lk_valid_i, lk_hit_i, lk_dirty_i, lk_unique_i   lookup result
//   rd_beat_o/rd_data_i       line read port, data returned combinationally
//   upd_valid_o/upd_op_o      one-cycle cache state-update command
//                             (01 clear unique+dirty, 11 clear unique, 10 inv)
//   dbg_state_o               current FSM state, for observation only
//
// Handshake rule for AC, CR and CD: a transfer happens on a rising clock edge
// where valid and ready are both high. Once a valid is raised here, it and its
// payload stay constant until that transfer; ready never depends on valid.
// ---------------------------------------------------------------------------
module ccu_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBytes = 64,
    localparam int unsigned NumBeats = LineBytes * 8 / DataWidth,
    localparam int unsigned BW       = $clog2(NumBeats)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 lk_req_o,
    output logic [AddrWidth-1:0] lk_addr_o,
    input  logic                 lk_valid_i,
    input  logic                 lk_hit_i,
    input  logic                 lk_dirty_i,
    input  logic                 lk_unique_i,
    output logic [BW-1:0]        rd_beat_o,
    input  logic [DataWidth-1:0] rd_data_i,
    output logic                 upd_valid_o,
    output logic [1:0]           upd_op_o,
    output logic [2:0]           dbg_state_o
);

    // Address bits that select the beat within the line.
    localparam int unsigned OffLo = $clog2(DataWidth / 8);
    localparam int unsigned OffHi = $clog2(LineBytes) - 1;

    localparam logic [1:0] OpNone     = 2'b00;
    localparam logic [1:0] OpClrAll   = 2'b01;
    localparam logic [1:0] OpClrUniq  = 2'b11;
    localparam logic [1:0] OpInval    = 2'b10;
    localparam logic [4:0] RespError  = 5'b00010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_RESP   = 3'd2,
        S_DATA   = 3'd3,
        S_UPD    = 3'd4
    } state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic [1:0]           op_q;
    logic [BW-1:0]        beat_q;      // next line beat to read
    logic [BW:0]          cnt_q;       // beats already loaded into cd_data_q
    logic                 ac_ready_q;
    logic                 lk_req_q;
    logic                 cr_valid_q;
    logic [4:0]           cr_resp_q;
    logic                 cd_valid_q;
    logic [DataWidth-1:0] cd_data_q;
    logic                 cd_last_q;
    logic                 upd_valid_q;

    logic [4:0]           resp_d;
    logic [1:0]           op_d;
    logic                 supported_d;

    function automatic logic is_supported(input logic [3:0] snoop);
        case (snoop)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0111, 4'b1000, 4'b1001, 4'b1101: is_supported = 1'b1;
            default:                             is_supported = 1'b0;
        endcase
    endfunction

    assign supported_d = is_supported(ac_snoop_i);

    // Response and follow-up cache op from the registered type and the
    // lookup result currently on lk_*_i (only consumed on lk_valid_i).
    always_comb begin
        logic wu, is_sh, pd, dt;
        wu    = lk_unique_i;
        is_sh = 1'b0;
        pd    = 1'b0;
        dt    = 1'b0;
        op_d  = OpNone;
        case (snoop_q)
            4'b0000: begin                      // ReadOnce
                dt = 1'b1; is_sh = 1'b1;
            end
            4'b0001, 4'b0011: begin             // ReadShared, ReadNotSharedDirty
                dt = 1'b1; is_sh = 1'b1; pd = lk_dirty_i; op_d = OpClrAll;
            end
            4'b0010: begin                      // ReadClean
                dt = 1'b1; is_sh = 1'b1; op_d = OpClrUniq;
            end
            4'b0111: begin                      // ReadUnique
                dt = 1'b1; pd = lk_dirty_i; op_d = OpInval;
            end
            4'b1000: begin                      // CleanShared
                dt = lk_dirty_i; pd = lk_dirty_i; is_sh = 1'b1;
                op_d = lk_dirty_i ? OpClrAll : OpNone;
            end
            4'b1001: begin                      // CleanInvalid
                dt = lk_dirty_i; pd = lk_dirty_i; op_d = OpInval;
            end
            4'b1101: begin                      // MakeInvalid
                op_d = OpInval;
            end
            default: ;
        endcase
        // A miss answers all-zero and leaves the cache untouched.
        if (!lk_hit_i) begin
            wu = 1'b0; is_sh = 1'b0; pd = 1'b0; dt = 1'b0; op_d = OpNone;
        end
        resp_d = {wu, is_sh, pd, 1'b0, dt};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            snoop_q     <= '0;
            op_q        <= OpNone;
            beat_q      <= '0;
            cnt_q       <= '0;
            ac_ready_q  <= 1'b1;
            lk_req_q    <= 1'b0;
            cr_valid_q  <= 1'b0;
            cr_resp_q   <= '0;
            cd_valid_q  <= 1'b0;
            cd_data_q   <= '0;
            cd_last_q   <= 1'b0;
            upd_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ac_valid_i && ac_ready_q) begin
                        addr_q     <= ac_addr_i;
                        snoop_q    <= ac_snoop_i;
                        beat_q     <= ac_addr_i[OffHi:OffLo];
                        ac_ready_q <= 1'b0;
                        op_q       <= OpNone;
                        if (supported_d) begin
                            lk_req_q <= 1'b1;
                            state_q  <= S_LOOKUP;
                        end else begin
                            // Unknown type: error response, cache not consulted.
                            cr_valid_q <= 1'b1;
                            cr_resp_q  <= RespError;
                            state_q    <= S_RESP;
                        end
                    end
                end

                S_LOOKUP: begin
                    if (lk_valid_i) begin
                        lk_req_q   <= 1'b0;
                        cr_valid_q <= 1'b1;
                        cr_resp_q  <= resp_d;
                        op_q       <= op_d;
                        state_q    <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (cr_ready_i) begin
                        cr_valid_q <= 1'b0;
                        if (cr_resp_q[0]) begin
                            // First beat loads on the CR handshake edge;
                            // rd_beat_o already points at the start beat.
                            cd_valid_q <= 1'b1;
                            cd_data_q  <= rd_data_i;
                            cd_last_q  <= 1'b0;
                            beat_q     <= beat_q + 1'b1;
                            cnt_q      <= (BW+1)'(1);
                            state_q    <= S_DATA;
                        end else if (op_q != OpNone) begin
                            upd_valid_q <= 1'b1;
                            state_q     <= S_UPD;
                        end else begin
                            ac_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    // cd_valid_q is always high here, so the load condition
                    // !cd_valid || cd_ready reduces to cd_ready_i.
                    if (cd_ready_i) begin
                        if (cd_last_q) begin
                            cd_valid_q <= 1'b0;
                            cd_last_q  <= 1'b0;
                            if (op_q != OpNone) begin
                                upd_valid_q <= 1'b1;
                                state_q     <= S_UPD;
                            end else begin
                                ac_ready_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end
                        end else begin
                            cd_data_q <= rd_data_i;
                            cd_last_q <= (cnt_q == (BW+1)'(NumBeats - 1));
                            beat_q    <= beat_q + 1'b1;
                            cnt_q     <= cnt_q + 1'b1;
                        end
                    end
                end

                S_UPD: begin
                    upd_valid_q <= 1'b0;
                    ac_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    state_q    <= S_IDLE;
                    ac_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ac_ready_o  = ac_ready_q;
    assign lk_req_o    = lk_req_q;
    assign lk_addr_o   = addr_q;
    assign cr_valid_o  = cr_valid_q;
    assign cr_resp_o   = cr_resp_q;
    assign cd_valid_o  = cd_valid_q;
    assign cd_data_o   = cd_data_q;
    assign cd_last_o   = cd_last_q;
    assign rd_beat_o   = beat_q;
    assign upd_valid_o = upd_valid_q;
    assign upd_op_o    = op_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// ---------------------------------------------------------------------------
// tb_ccu_snoop_responder
//
// Directed bench for ccu_snoop_responder with LineBytes=64, DataWidth=64
// (8 beats per line). The cache is modelled as a fixed line whose beat k
// holds beat_val(k); expected responses, beat orders and update ops are
// written out by hand per scenario.
// ---------------------------------------------------------------------------
module tb_ccu_snoop_responder;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          ac_valid_i, ac_ready_o;
    logic [AW-1:0] ac_addr_i;
    logic [3:0]    ac_snoop_i;
    logic          cr_valid_o, cr_ready_i;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o, cd_ready_i;
    logic [DW-1:0] cd_data_o;
    logic          cd_last_o;
    logic          lk_req_o;
    logic [AW-1:0] lk_addr_o;
    logic          lk_valid_i, lk_hit_i, lk_dirty_i, lk_unique_i;
    logic [2:0]    rd_beat_o;
    logic [DW-1:0] rd_data_i;
    logic          upd_valid_o;
    logic [1:0]    upd_op_o;
    logic [2:0]    dbg_state_o;

    ccu_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineBytes(64)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ac_valid_i  (ac_valid_i),
        .ac_ready_o  (ac_ready_o),
        .ac_addr_i   (ac_addr_i),
        .ac_snoop_i  (ac_snoop_i),
        .cr_valid_o  (cr_valid_o),
        .cr_ready_i  (cr_ready_i),
        .cr_resp_o   (cr_resp_o),
        .cd_valid_o  (cd_valid_o),
        .cd_ready_i  (cd_ready_i),
        .cd_data_o   (cd_data_o),
        .cd_last_o   (cd_last_o),
        .lk_req_o    (lk_req_o),
        .lk_addr_o   (lk_addr_o),
        .lk_valid_i  (lk_valid_i),
        .lk_hit_i    (lk_hit_i),
        .lk_dirty_i  (lk_dirty_i),
        .lk_unique_i (lk_unique_i),
        .rd_beat_o   (rd_beat_o),
        .rd_data_i   (rd_data_i),
        .upd_valid_o (upd_valid_o),
        .upd_op_o    (upd_op_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- cache line model ----------------
    function automatic logic [DW-1:0] beat_val(input int k);
        beat_val = {32'hC0DE_0000 + 32'(k), 32'hBEEF_0000 + 32'(k * 16)};
    endfunction

    assign rd_data_i = beat_val(int'(rd_beat_o));

    // ---------------- monitors ----------------
    int upd_cnt = 0;
    int lk_cnt  = 0;
    always @(negedge clk) begin
        if (upd_valid_o) upd_cnt++;
        if (lk_req_o)    lk_cnt++;
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ac(input logic [AW-1:0] addr, input logic [3:0] snoop);
        int guard;
        guard = 0;
        ac_valid_i = 1'b1;
        ac_addr_i  = addr;
        ac_snoop_i = snoop;
        while (!ac_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        if (!ac_ready_o) chk("ac_ready_timeout", 64'(ac_ready_o), 64'd1);
        tick();
        ac_valid_i = 1'b0;
    endtask

    task automatic do_lookup(input logic [AW-1:0] addr, input logic hit, input logic dirty,
                             input logic uniq, input int lat);
        int guard;
        guard = 0;
        while (!lk_req_o && guard < 20) begin
            tick();
            guard++;
        end
        chk("lk_req", 64'(lk_req_o), 64'd1);
        chk("lk_addr", lk_addr_o, addr);
        for (int i = 0; i < lat; i++) tick();
        lk_valid_i  = 1'b1;
        lk_hit_i    = hit;
        lk_dirty_i  = dirty;
        lk_unique_i = uniq;
        tick();
        lk_valid_i  = 1'b0;
        lk_hit_i    = 1'b0;
        lk_dirty_i  = 1'b0;
        lk_unique_i = 1'b0;
        chk("lk_req_drop", 64'(lk_req_o), 64'd0);
    endtask

    task automatic take_cr(input logic [4:0] exp_resp, input int stall);
        int guard;
        guard = 0;
        while (!cr_valid_o && guard < 20) begin
            tick();
            guard++;
        end
        chk("cr_valid", 64'(cr_valid_o), 64'd1);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("cr_hold_valid", 64'(cr_valid_o), 64'd1);
            chk("cr_hold_resp", 64'(cr_resp_o), 64'(exp_resp));
        end
        chk("cr_resp", 64'(cr_resp_o), 64'(exp_resp));
        cr_ready_i = 1'b1;
        tick();
        cr_ready_i = 1'b0;
    endtask

    task automatic load_line(input int start);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(beat_val((start + i) % 8));
    endtask

    // Accept n_hs beats; optionally hold ready low for stall_len cycles when
    // beat number stall_at (0-based) is presented. Returns cycles spent.
    task automatic collect_cd(input int n_hs, input int stall_at, input int stall_len,
                              output int cycles);
        int seen, guard;
        logic [DW-1:0] held_d, exp_d;
        logic held_l;
        bit stalled;
        seen = 0; guard = 0; cycles = 0; stalled = 0;
        cd_ready_i = 1'b1;
        while (seen < n_hs && guard < 100) begin
            guard++;
            if (cd_valid_o) begin
                if (seen == stall_at && !stalled && stall_len > 0) begin
                    stalled = 1;
                    held_d = cd_data_o;
                    held_l = cd_last_o;
                    cd_ready_i = 1'b0;
                    for (int k = 0; k < stall_len; k++) begin
                        tick();
                        cycles++;
                        chk("cd_hold_valid", 64'(cd_valid_o), 64'd1);
                        chk("cd_hold_data", cd_data_o, held_d);
                        chk("cd_hold_last", 64'(cd_last_o), 64'(held_l));
                    end
                    cd_ready_i = 1'b1;
                end
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("cd_data", cd_data_o, exp_d);
                chk("cd_last", 64'(cd_last_o), 64'(exp_q.size() == 0));
                seen++;
            end
            tick();
            cycles++;
        end
        cd_ready_i = 1'b0;
        if (seen < n_hs) chk("cd_timeout", 64'(seen), 64'(n_hs));
    endtask

    // After the last CD handshake: expect exactly one update pulse with op.
    task automatic expect_upd(input logic [1:0] op, input int cnt_before);
        chk("upd_not_early", 64'(upd_cnt), 64'(cnt_before));
        chk("upd_valid", 64'(upd_valid_o), 64'd1);
        chk("upd_op", 64'(upd_op_o), 64'(op));
        tick();
        chk("upd_drop", 64'(upd_valid_o), 64'd0);
        chk("ac_ready_after_upd", 64'(ac_ready_o), 64'd1);
        tick();
        chk("upd_once", 64'(upd_cnt), 64'(cnt_before + 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, u0, l0;
        rst_i = 1'b1;
        ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0;
        cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        lk_valid_i = 1'b0; lk_hit_i = 1'b0; lk_dirty_i = 1'b0; lk_unique_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        // Reset state
        chk("rst_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("rst_cr_valid", 64'(cr_valid_o), 64'd0);
        chk("rst_cd_valid", 64'(cd_valid_o), 64'd0);
        chk("rst_lk_req", 64'(lk_req_o), 64'd0);
        chk("rst_upd_valid", 64'(upd_valid_o), 64'd0);
        chk("rst_cr_resp", 64'(cr_resp_o), 64'd0);
        chk("rst_cd_data", cd_data_o, 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'd0);

        // 1: ReadShared 0x1028 hit dirty unique -> 0x1D, beats 5..4, op 01
        send_ac(64'h1028, 4'b0001);
        chk("busy_ac_ready", 64'(ac_ready_o), 64'd0);
        do_lookup(64'h1028, 1'b1, 1'b1, 1'b1, 2);
        take_cr(5'h1D, 2);
        chk("cd_first_valid", 64'(cd_valid_o), 64'd1);
        load_line(5);
        u0 = upd_cnt;
        collect_cd(8, -1, 0, cyc);
        chk("cd_cycles", 64'(cyc), 64'd8);
        expect_upd(2'b01, u0);

        // 2: ReadUnique miss -> 0, no CD, no update, ready right after CR
        u0 = upd_cnt;
        send_ac(64'h2040, 4'b0111);
        do_lookup(64'h2040, 1'b0, 1'b0, 1'b0, 0);
        take_cr(5'h00, 0);
        chk("miss_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("miss_cd_valid", 64'(cd_valid_o), 64'd0);
        chk("miss_upd", 64'(upd_valid_o), 64'd0);
        tick();
        chk("miss_upd_cnt", 64'(upd_cnt), 64'(u0));

        // 3: CleanInvalid hit clean shared -> 0, no CD, op 10
        u0 = upd_cnt;
        send_ac(64'h3000, 4'b1001);
        do_lookup(64'h3000, 1'b1, 1'b0, 1'b0, 1);
        take_cr(5'h00, 0);
        chk("ci_cd_valid", 64'(cd_valid_o), 64'd0);
        expect_upd(2'b10, u0);

        // 4: unsupported type 0100 -> no lookup, resp 00010
        l0 = lk_cnt;
        u0 = upd_cnt;
        send_ac(64'h4000, 4'b0100);
        take_cr(5'b00010, 1);
        chk("unsup_lk_none", 64'(lk_cnt), 64'(l0));
        chk("unsup_ac_ready", 64'(ac_ready_o), 64'd1);
        chk("unsup_cd_valid", 64'(cd_valid_o), 64'd0);
        tick();
        chk("unsup_upd_cnt", 64'(upd_cnt), 64'(u0));

        // 5: ReadClean 0x2000 hit clean unique -> 0x19; stall 3 at beat 2; op 11
        send_ac(64'h2000, 4'b0010);
        do_lookup(64'h2000, 1'b1, 1'b0, 1'b1, 0);
        take_cr(5'h19, 0);
        load_line(0);
        u0 = upd_cnt;
        collect_cd(8, 2, 3, cyc);
        chk("stall_cycles", 64'(cyc), 64'd11);
        expect_upd(2'b11, u0);

        // 6: ReadUnique 0x0038 hit dirty unique -> 0x15; reset during beat 3
        send_ac(64'h0038, 4'b0111);
        do_lookup(64'h0038, 1'b1, 1'b1, 1'b1, 0);
        take_cr(5'h15, 0);
        load_line(7);
        u0 = upd_cnt;
        collect_cd(3, -1, 0, cyc);
        chk("pre_rst_beat3", cd_data_o, beat_val(2));
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_cd_valid", 64'(cd_valid_o), 64'd0);
        chk("abort_cr_valid", 64'(cr_valid_o), 64'd0);
        chk("abort_lk_req", 64'(lk_req_o), 64'd0);
        chk("abort_upd", 64'(upd_valid_o), 64'd0);
        chk("abort_ac_ready", 64'(ac_ready_o), 64'd1);
        tick(); tick(); tick();
        chk("abort_no_upd", 64'(upd_cnt), 64'(u0));
        chk("abort_state", 64'(dbg_state_o), 64'd0);

        // 7: CleanShared 0x1078 hit dirty shared -> 0x0D, beats 7..6, op 01
        send_ac(64'h1078, 4'b1000);
        do_lookup(64'h1078, 1'b1, 1'b1, 1'b0, 3);
        take_cr(5'h0D, 0);
        load_line(7);
        u0 = upd_cnt;
        collect_cd(8, -1, 0, cyc);
        expect_upd(2'b01, u0);

        // 8: MakeInvalid hit unique -> 0x10, no CD, op 10
        send_ac(64'h5000, 4'b1101);
        do_lookup(64'h5000, 1'b1, 1'b1, 1'b1, 0);
        u0 = upd_cnt;
        take_cr(5'h10, 0);
        chk("mi_cd_valid", 64'(cd_valid_o), 64'd0);
        expect_upd(2'b10, u0);

        // 9: ReadOnce hit dirty shared -> 0x09, full line, no update
        send_ac(64'h0010, 4'b0000);
        do_lookup(64'h0010, 1'b1, 1'b1, 1'b0, 0);
        take_cr(5'h09, 0);
        load_line(2);
        u0 = upd_cnt;
        collect_cd(8, -1, 0, cyc);
        chk("ro_no_upd", 64'(upd_valid_o), 64'd0);
        chk("ro_ac_ready", 64'(ac_ready_o), 64'd1);
        tick();
        chk("ro_upd_cnt", 64'(upd_cnt), 64'(u0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
